// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache.
// Single-word core port, 128-bit line port to the data DRAM.
module l1_dcache #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [31:0]           cpu_req_wdata,
    input  logic [3:0]            cpu_req_wmask,
    output logic                  cpu_rep_valid,
    output logic [31:0]           cpu_rep_rdata,
    output logic                  mem_r_req_valid,
    input  logic                  mem_r_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_r_req_addr,
    input  logic                  mem_r_rep_valid,
    input  logic [LINE_WIDTH-1:0] mem_r_rep_rdata,
    output logic                  mem_w_req_valid,
    input  logic                  mem_w_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_w_req_addr,
    output logic [LINE_WIDTH-1:0] mem_w_req_wdata,
    input  logic                  mem_w_rep_valid
);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - 4 - IW;

    typedef enum logic [2:0] {
        IDLE, TAG_CHECK, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RESPOND
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q;
    logic [TW-1:0]         tag_req_q;
    logic [IW-1:0]         idx_q;
    logic [1:0]            word_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;

    logic [SETS-1:0]       valid_q;
    logic [SETS-1:0]       dirty_q;
    logic [TW-1:0]         tag_arr_q  [SETS];
    logic [LINE_WIDTH-1:0] data_arr_q [SETS];

    logic                  rep_valid_q;
    logic [31:0]           rep_rdata_q;

    logic [LINE_WIDTH-1:0] line;
    logic [LINE_WIDTH-1:0] line_upd;
    logic [31:0]           word_rd;
    logic [31:0]           word_mg;
    logic                  hit;
    logic                  access;
    logic                  refill;
    logic                  wb_done;
    logic                  req_fire;
    logic                  unused_addr;

    assign unused_addr = ^cpu_req_addr[1:0];

    assign line     = data_arr_q[idx_q];
    assign word_rd  = line[{word_q, 5'b0} +: 32];
    assign hit      = valid_q[idx_q] && (tag_arr_q[idx_q] == tag_req_q);
    assign access   = (state_q == TAG_CHECK && hit) || (state_q == RESPOND);
    assign refill   = (state_q == RF_WAIT) && mem_r_rep_valid;
    assign wb_done  = (state_q == WB_WAIT) && mem_w_rep_valid;
    assign req_fire = cpu_req_valid && cpu_req_ready;

    // Byte merge of store data into the addressed word of the line.
    always_comb begin
        word_mg = word_rd;
        for (int b = 0; b < 4; b++) begin
            if (wmask_q[b]) word_mg[8*b +: 8] = wdata_q[8*b +: 8];
        end
        line_upd = line;
        line_upd[{word_q, 5'b0} +: 32] = word_mg;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (req_fire) state_d = TAG_CHECK;
            TAG_CHECK: begin
                if (hit)                                  state_d = IDLE;
                else if (valid_q[idx_q] && dirty_q[idx_q]) state_d = WB_REQ;
                else                                      state_d = RF_REQ;
            end
            WB_REQ:    if (mem_w_req_ready) state_d = WB_WAIT;
            WB_WAIT:   if (mem_w_rep_valid) state_d = RF_REQ;
            RF_REQ:    if (mem_r_req_ready) state_d = RF_WAIT;
            RF_WAIT:   if (mem_r_rep_valid) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            rep_valid_q <= 1'b0;
            rep_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rep_valid_q <= access;
            if (access) rep_rdata_q <= we_q ? word_mg : word_rd;
            if (refill) begin
                valid_q[idx_q] <= 1'b1;
                dirty_q[idx_q] <= 1'b0;
            end
            if (wb_done) dirty_q[idx_q] <= 1'b0;
            if (access && we_q && (|wmask_q)) dirty_q[idx_q] <= 1'b1;
        end
    end

    // Request latch and tag/data arrays carry no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_q      <= cpu_req_we;
            tag_req_q <= cpu_req_addr[ADDR_WIDTH-1 -: TW];
            idx_q     <= cpu_req_addr[4 +: IW];
            word_q    <= cpu_req_addr[3:2];
            wdata_q   <= cpu_req_wdata;
            wmask_q   <= cpu_req_wmask;
        end
        if (refill) begin
            data_arr_q[idx_q] <= mem_r_rep_rdata;
            tag_arr_q[idx_q]  <= tag_req_q;
        end else if (access && we_q) begin
            data_arr_q[idx_q] <= line_upd;
        end
    end

    assign cpu_req_ready   = (state_q == IDLE) && !rst;
    assign cpu_rep_valid   = rep_valid_q;
    assign cpu_rep_rdata   = rep_rdata_q;
    assign mem_w_req_valid = (state_q == WB_REQ);
    assign mem_w_req_addr  = {tag_arr_q[idx_q], idx_q, 4'b0};
    assign mem_w_req_wdata = line;
    assign mem_r_req_valid = (state_q == RF_REQ);
    assign mem_r_req_addr  = {tag_req_q, idx_q, 4'b0};

endmodule

// File: tb/tb_l1_dcache.sv
// Bench for l1_dcache: DRAM responder plus a flat-memory and
// per-set residency model predicting replies, traffic and latency.
module tb_l1_dcache;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic         cpu_req_we;
    logic [31:0]  cpu_req_addr;
    logic [31:0]  cpu_req_wdata;
    logic [3:0]   cpu_req_wmask;
    logic         cpu_rep_valid;
    logic [31:0]  cpu_rep_rdata;
    logic         mem_r_req_valid;
    logic         mem_r_req_ready;
    logic [31:0]  mem_r_req_addr;
    logic         mem_r_rep_valid;
    logic [127:0] mem_r_rep_rdata;
    logic         mem_w_req_valid;
    logic         mem_w_req_ready;
    logic [31:0]  mem_w_req_addr;
    logic [127:0] mem_w_req_wdata;
    logic         mem_w_rep_valid;

    l1_dcache dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_req_we      (cpu_req_we),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_wdata   (cpu_req_wdata),
        .cpu_req_wmask   (cpu_req_wmask),
        .cpu_rep_valid   (cpu_rep_valid),
        .cpu_rep_rdata   (cpu_rep_rdata),
        .mem_r_req_valid (mem_r_req_valid),
        .mem_r_req_ready (mem_r_req_ready),
        .mem_r_req_addr  (mem_r_req_addr),
        .mem_r_rep_valid (mem_r_rep_valid),
        .mem_r_rep_rdata (mem_r_rep_rdata),
        .mem_w_req_valid (mem_w_req_valid),
        .mem_w_req_ready (mem_w_req_ready),
        .mem_w_req_addr  (mem_w_req_addr),
        .mem_w_req_wdata (mem_w_req_wdata),
        .mem_w_rep_valid (mem_w_rep_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DRAM contents and CPU-visible words written by stores.
    logic [127:0] mem  [logic [31:0]];
    logic [31:0]  refw [logic [31:0]];
    bit           mvalid [16];
    bit           mdirty [16];
    int           mtag   [16];

    // Responder bookkeeping.
    int           r_stall = 0, w_stall = 0;
    int           r_left = 0, w_left = 0;
    int           r_cd = 0, w_cd = 0;
    bit           r_seen = 0, w_seen = 0, w_out = 0;
    logic [31:0]  r_first, w_first, r_acc, w_acc;
    logic [127:0] w_first_d, w_acc_d;
    int           n_rd = 0, n_wr = 0;
    bit           both_err = 0, r_unst = 0, w_unst = 0, ord_err = 0;

    function automatic logic [127:0] init_line(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++)
            l[32*i +: 32] = ((la + 32'(i)) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [127:0] dram_line(input logic [31:0] la);
        return mem.exists(la) ? mem[la] : init_line(la);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [127:0] l;
        logic [31:0]  wa;
        wa = a >> 2;
        if (refw.exists(wa)) return refw[wa];
        l = dram_line(a & ~32'hF);
        return l[32*a[3:2] +: 32];
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = ref_word(la + 32'(4*i));
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0]  m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line-wide DRAM: accepts after a programmable stall, replies 2 cycles later.
    initial begin
        mem_r_req_ready = 0; mem_r_rep_valid = 0; mem_r_rep_rdata = '0;
        mem_w_req_ready = 0; mem_w_rep_valid = 0;
        forever begin
            @(negedge clk);
            mem_r_rep_valid = 0;
            mem_w_rep_valid = 0;
            mem_r_req_ready = 0;
            mem_w_req_ready = 0;
            if (r_cd > 0) begin
                r_cd--;
                if (r_cd == 0) begin
                    mem_r_rep_valid = 1;
                    mem_r_rep_rdata = dram_line(r_acc);
                end
            end
            if (w_cd > 0) begin
                w_cd--;
                if (w_cd == 0) begin
                    mem_w_rep_valid = 1;
                    w_out = 0;
                end
            end
            if (mem_r_req_valid && mem_w_req_valid) both_err = 1;
            if (mem_w_req_valid) begin
                if (!w_seen) begin
                    w_seen = 1; w_first = mem_w_req_addr;
                    w_first_d = mem_w_req_wdata; w_left = w_stall;
                end else if (mem_w_req_addr !== w_first ||
                             mem_w_req_wdata !== w_first_d) w_unst = 1;
                if (w_left > 0) w_left--;
                else begin
                    mem_w_req_ready = 1; n_wr++; w_seen = 0;
                    w_acc = mem_w_req_addr; w_acc_d = mem_w_req_wdata;
                    mem[w_acc] = w_acc_d; w_cd = 2; w_out = 1;
                end
            end
            if (mem_r_req_valid) begin
                if (!r_seen) begin
                    r_seen = 1; r_first = mem_r_req_addr; r_left = r_stall;
                    if (w_out) ord_err = 1;
                end else if (mem_r_req_addr !== r_first) r_unst = 1;
                if (r_left > 0) r_left--;
                else begin
                    mem_r_req_ready = 1; n_rd++; r_seen = 0;
                    r_acc = mem_r_req_addr; r_cd = 2;
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm,
                          input int rs, input int ws, input string nm,
                          output logic [31:0] got);
        int           s, tg, k, lat, rd0, wr0, exp_lat;
        bit           hit, wb;
        logic [31:0]  vaddr, old, exp;
        logic [127:0] vline;
        s     = int'((a >> 4) & 32'hF);
        tg    = int'(a >> 8);
        hit   = mvalid[s] && mtag[s] == tg;
        wb    = !hit && mvalid[s] && mdirty[s];
        vaddr = (32'(mtag[s]) << 8) | (32'(s) << 4);
        vline = ref_line(vaddr);
        old   = ref_word(a);
        exp   = we ? merge(old, wd, wm) : old;
        exp_lat = hit ? 2 : 6 + rs + (wb ? 3 + ws : 0);
        r_stall = rs; w_stall = ws;
        rd0 = n_rd; wr0 = n_wr;
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = a;
        cpu_req_wdata = wd; cpu_req_wmask = wm;
        k = 0;
        while (!cpu_req_ready && k < 50) begin @(negedge clk); k++; end
        chk({nm, " req_ready"}, 128'(cpu_req_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 0;
        lat = 1;
        while (!cpu_rep_valid && lat < 300) begin @(negedge clk); lat++; end
        got = cpu_rep_rdata;
        chk({nm, " rep_valid"}, 128'(cpu_rep_valid), 128'(1));
        chk({nm, " rdata"}, 128'(cpu_rep_rdata), 128'(exp));
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " reads"}, 128'(n_rd - rd0), 128'(hit ? 0 : 1));
        chk({nm, " writes"}, 128'(n_wr - wr0), 128'(wb ? 1 : 0));
        if (!hit) chk({nm, " rd_addr"}, 128'(r_acc), 128'(a & ~32'hF));
        if (wb) begin
            chk({nm, " wr_addr"}, 128'(w_acc), 128'(vaddr));
            chk({nm, " wr_data"}, w_acc_d, vline);
        end
        @(negedge clk);
        chk({nm, " rep_pulse"}, 128'(cpu_rep_valid), 128'(0));
        if (we) refw[a >> 2] = exp;
        mdirty[s] = (hit && mdirty[s]) || (we && wm != 4'b0);
        mvalid[s] = 1;
        mtag[s]   = tg;
    endtask

    initial begin
        logic [31:0]  got, a, wd;
        logic [127:0] seed;
        logic [3:0]   wm;
        bit           we;
        int           rd0, k, pulses;

        rst = 1; cpu_req_valid = 0; cpu_req_we = 0;
        cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_wmask = '0;
        foreach (mvalid[i]) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = 0; end
        seed = init_line(32'h40);
        seed[63:32] = 32'h1122_3344;
        mem[32'h40] = seed;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 128'(cpu_req_ready), 128'(0));
        chk("rst rep_valid", 128'(cpu_rep_valid), 128'(0));
        chk("rst rep_rdata", 128'(cpu_rep_rdata), 128'(0));
        chk("rst r_valid", 128'(mem_r_req_valid), 128'(0));
        chk("rst w_valid", 128'(mem_w_req_valid), 128'(0));
        rst = 0;

        do_req(0, 32'h40, 0, 0, 0, 0, "cold_ld", got);
        do_req(0, 32'h40, 0, 0, 0, 0, "hit_ld", got);
        do_req(1, 32'h44, 32'hDEAD_BEEF, 4'b0011, 0, 0, "st_hit", got);
        chk("st_merge_const", 128'(got), 128'(32'h1122_BEEF));
        do_req(0, 32'h140, 0, 0, 0, 0, "dirty_evict", got);
        chk("wb_merged_word", 128'(w_acc_d[63:32]), 128'(32'h1122_BEEF));
        chk("order", 128'(ord_err), 128'(0));
        do_req(0, 32'h200, 0, 0, 5, 0, "rd_stall", got);
        chk("rd_stable", 128'(r_unst), 128'(0));
        do_req(0, 32'h80, 0, 0, 0, 0, "m0_ld", got);
        do_req(1, 32'h84, 32'hCAFE_F00D, 4'b0000, 0, 0, "m0_st", got);
        do_req(0, 32'h180, 0, 0, 0, 0, "m0_evict", got);

        for (int i = 0; i < 150; i++) begin
            a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 5) << 4) |
                 ($urandom_range(0, 3) << 2);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            wm = 4'($urandom_range(0, 15));
            do_req(we, a, wd, wm, $urandom_range(0, 3), $urandom_range(0, 3),
                   "rnd", got);
        end

        // Reset while the refill is outstanding.
        rd0 = n_rd; r_stall = 0; w_stall = 0;
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h700;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 0;
        k = 0;
        while (n_rd == rd0 && k < 100) begin @(negedge clk); #1; k++; end
        chk("rstmid accepted", 128'(n_rd - rd0), 128'(1));
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_rep_valid) pulses++;
        end
        chk("rstmid no_reply", 128'(pulses), 128'(0));
        foreach (mvalid[i]) begin mvalid[i] = 0; mdirty[i] = 0; end
        refw.delete();
        do_req(0, 32'h700, 0, 0, 0, 0, "rstmid remiss", got);

        chk("both_valid", 128'(both_err), 128'(0));
        chk("rd_stable_all", 128'(r_unst), 128'(0));
        chk("wr_stable_all", 128'(w_unst), 128'(0));
        chk("order_all", 128'(ord_err), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
